// File: rtl/button_conditioner.sv
// Multi-channel pushbutton conditioner: 2-flop sync, stability-count debounce,
// press/release strobes, long-press hold level and auto-repeat strobes.
// release/repeat are reserved words, so those outputs are release_pulse/repeat_pulse.
module button_conditioner #(
  parameter int NCH          = 4,
  parameter int NDELAY       = 650000,
  parameter int NBITS        = 20,
  parameter int ACTIVE_LOW   = 0,
  parameter int TICK_DIV     = 65000,
  parameter int PBITS        = 17,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int TBITS        = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   noisy,
  output logic [NCH-1:0]   clean,
  output logic [NCH-1:0]   press,
  output logic [NCH-1:0]   release_pulse,
  output logic [NCH-1:0]   hold,
  output logic [NCH-1:0]   repeat_pulse,
  output logic [2*NCH-1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  localparam logic [NBITS-1:0] DLY       = NBITS'(NDELAY);
  localparam logic [PBITS-1:0] TICK_LAST = PBITS'(TICK_DIV - 1);
  localparam logic [TBITS-1:0] HOLD_LAST = TBITS'(HOLD_TICKS - 1);
  localparam logic [TBITS-1:0] REP_LAST  = TBITS'((REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1);
  localparam logic             REP_EN    = (REPEAT_TICKS != 0);

  logic [NCH-1:0]   in_pol;
  logic [PBITS-1:0] pcnt;
  logic             tick;

  assign in_pol = (ACTIVE_LOW != 0) ? ~noisy : noisy;

  // Shared free-running prescaler; tick marks the last count before wrap.
  assign tick = (pcnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic             sync1, sync2, xnew;
    logic             clean_q, press_q, release_q, hold_q, repeat_q;
    logic [NBITS-1:0] count;
    logic             settled, rise, fall;
    state_t           state, state_nx;
    logic [TBITS-1:0] hold_cnt, hold_cnt_nx, rep_cnt, rep_cnt_nx;
    logic             hold_nx, repeat_nx;

    // rise/fall are the edges on which clean is about to change; the FSM acts
    // on them directly so hold drops in the same cycle release is visible.
    assign settled = (sync2 == xnew) && (count == DLY);
    assign rise    = settled && xnew && !clean_q;
    assign fall    = settled && !xnew && clean_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1     <= 1'b0;
        sync2     <= 1'b0;
        xnew      <= 1'b0;
        count     <= '0;
        clean_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        state     <= ST_IDLE;
        hold_cnt  <= '0;
        rep_cnt   <= '0;
        hold_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        sync1 <= in_pol[g];
        sync2 <= sync1;
        if (sync2 != xnew) begin
          xnew  <= sync2;
          count <= '0;
        end else if (count == DLY) begin
          clean_q <= xnew;
        end else begin
          count <= count + 1'b1;
        end
        press_q   <= rise;
        release_q <= fall;
        state     <= state_nx;
        hold_cnt  <= hold_cnt_nx;
        rep_cnt   <= rep_cnt_nx;
        hold_q    <= hold_nx;
        repeat_q  <= repeat_nx;
      end
    end

    always_comb begin
      state_nx    = state;
      hold_cnt_nx = hold_cnt;
      rep_cnt_nx  = rep_cnt;
      hold_nx     = hold_q;
      repeat_nx   = 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state_nx    = ST_PRESSED;
            hold_cnt_nx = '0;
          end
        end
        ST_PRESSED: begin
          if (fall) begin
            state_nx    = ST_IDLE;
            hold_cnt_nx = '0;
            rep_cnt_nx  = '0;
            hold_nx     = 1'b0;
          end else if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state_nx   = ST_HELD;
              hold_nx    = 1'b1;
              repeat_nx  = 1'b1;
              rep_cnt_nx = '0;
            end else begin
              hold_cnt_nx = hold_cnt + 1'b1;
            end
          end
        end
        ST_HELD: begin
          // Release beats a same-cycle tick, so no repeat can escape on release.
          if (fall) begin
            state_nx    = ST_IDLE;
            hold_cnt_nx = '0;
            rep_cnt_nx  = '0;
            hold_nx     = 1'b0;
          end else if (tick && REP_EN) begin
            if (rep_cnt == REP_LAST) begin
              repeat_nx  = 1'b1;
              rep_cnt_nx = '0;
            end else begin
              rep_cnt_nx = rep_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nx    = ST_IDLE;
          hold_cnt_nx = '0;
          rep_cnt_nx  = '0;
          hold_nx     = 1'b0;
        end
      endcase
    end

    assign clean[g]           = clean_q;
    assign press[g]           = press_q;
    assign release_pulse[g]   = release_q;
    assign hold[g]            = hold_q;
    assign repeat_pulse[g]    = repeat_q;
    assign state_dbg[2*g +: 2] = state;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: strobe/hold events go through an expected-event
// queue checked by a monitor; level checks are done inline.
module tb_button_conditioner;
  localparam int NCH = 2;
  localparam int W   = 20;
  localparam logic [2:0] K_PRESS = 3'd0, K_REL = 3'd1, K_REP = 3'd2,
                         K_HRISE = 3'd3, K_HFALL = 3'd4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   noisy = '0;
  logic [NCH-1:0]   clean, press, release_pulse, hold, repeat_pulse;
  logic [2*NCH-1:0] state_dbg;
  logic [NCH-1:0]   noisy_al = '1;
  logic [NCH-1:0]   clean_al, press_al, release_al, hold_al, repeat_al;
  logic [2*NCH-1:0] state_al;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0]   exp_q[$];
  logic [NCH-1:0] hold_prev = '0;

  button_conditioner #(
    .NCH(2), .NDELAY(4), .NBITS(3), .ACTIVE_LOW(0), .TICK_DIV(10), .PBITS(4),
    .HOLD_TICKS(3), .REPEAT_TICKS(2), .TBITS(2)
  ) dut (
    .clk(clk), .reset(reset), .noisy(noisy), .clean(clean), .press(press),
    .release_pulse(release_pulse), .hold(hold), .repeat_pulse(repeat_pulse),
    .state_dbg(state_dbg)
  );

  button_conditioner #(
    .NCH(2), .NDELAY(4), .NBITS(3), .ACTIVE_LOW(1), .TICK_DIV(10), .PBITS(4),
    .HOLD_TICKS(3), .REPEAT_TICKS(2), .TBITS(2)
  ) dut_al (
    .clk(clk), .reset(reset), .noisy(noisy_al), .clean(clean_al), .press(press_al),
    .release_pulse(release_al), .hold(hold_al), .repeat_pulse(repeat_al),
    .state_dbg(state_al)
  );

  // clock/reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  function automatic logic [W-1:0] ev(input logic [2:0] k, input int c, input int t);
    logic [0:0]  cb;
    logic [15:0] tb;
    cb = c[0:0];
    tb = t[15:0];
    return {k, cb, tb};
  endfunction

  task automatic expect_ev(input logic [2:0] k, input int c, input int t);
    exp_q.push_back(ev(k, c, t));
  endtask

  task automatic sb_check(input logic [W-1:0] act);
    logic [W-1:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_unexpected: got kind=%0d ch=%0d cyc=%0d, required no event",
               act[19:17], act[16], act[15:0]);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL sb_event: got kind=%0d ch=%0d cyc=%0d, required kind=%0d ch=%0d cyc=%0d",
                 act[19:17], act[16], act[15:0], e[19:17], e[16], e[15:0]);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // monitor: turns DUT strobes and hold edges into events for the scoreboard
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        for (int c = 0; c < NCH; c++) begin
          if (press[c] === 1'b1)         sb_check(ev(K_PRESS, c, cyc));
          if (release_pulse[c] === 1'b1) sb_check(ev(K_REL, c, cyc));
          if (repeat_pulse[c] === 1'b1)  sb_check(ev(K_REP, c, cyc));
          if (hold[c] === 1'b1 && hold_prev[c] === 1'b0) sb_check(ev(K_HRISE, c, cyc));
          if (hold[c] !== 1'b1 && hold_prev[c] === 1'b1) sb_check(ev(K_HFALL, c, cyc));
          hold_prev[c] = hold[c];
        end
      end
    end
  endtask

  // driver tasks
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] e;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    chk("rst_clean", clean, 0);
    chk("rst_press", press, 0);
    chk("rst_release", release_pulse, 0);
    chk("rst_hold", hold, 0);
    chk("rst_repeat", repeat_pulse, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_clean_al", clean_al, 0);

    // A: clean press on ch0, hold/repeat, release landing on a repeat tick
    expect_ev(K_PRESS, 0, 8);
    expect_ev(K_REP, 0, 30);
    expect_ev(K_HRISE, 0, 30);
    expect_ev(K_REP, 0, 50);
    expect_ev(K_REP, 0, 70);
    expect_ev(K_REL, 0, 90);
    expect_ev(K_HFALL, 0, 90);
    noisy[0] = 1'b1;
    wait_cyc(7);
    chk("a_clean_not_early", clean, 0);
    wait_cyc(8);
    chk("a_press", press, 2'b01);
    chk("a_clean", clean, 2'b01);
    wait_cyc(9);
    chk("a_press_one_cycle", press, 0);
    chk("a_clean_ch1_idle", clean, 2'b01);
    chk("a_state_pressed", state_dbg, 4'b0001);
    wait_cyc(31);
    chk("a_hold", hold, 2'b01);
    chk("a_state_held", state_dbg, 4'b0010);
    wait_cyc(82);
    noisy[0] = 1'b0;
    wait_cyc(90);
    chk("a_release_on_tick", release_pulse, 2'b01);
    chk("a_no_repeat_on_release", repeat_pulse, 0);
    chk("a_hold_drop", hold, 0);
    wait_cyc(91);
    chk("a_no_repeat_after", repeat_pulse, 0);
    chk("a_state_idle", state_dbg, 0);
    wait_cyc(110);

    // B: bounce on ch0, 5-cycle pulse rejected and 6-cycle pulse accepted on ch1
    do_reset();
    expect_ev(K_PRESS, 0, 13);
    expect_ev(K_REL, 0, 23);
    expect_ev(K_PRESS, 1, 38);
    expect_ev(K_REL, 1, 44);
    noisy = 2'b11;
    wait_cyc(3);
    noisy[0] = 1'b0;
    wait_cyc(5);
    noisy = 2'b01;
    wait_cyc(12);
    chk("b_no_press_in_bounce", clean, 0);
    wait_cyc(15);
    noisy[0] = 1'b0;
    wait_cyc(30);
    noisy[1] = 1'b1;
    wait_cyc(36);
    noisy[1] = 1'b0;
    wait_cyc(60);

    // C: hold/repeat on ch1, release away from a tick
    do_reset();
    expect_ev(K_PRESS, 1, 12);
    expect_ev(K_REP, 1, 40);
    expect_ev(K_HRISE, 1, 40);
    expect_ev(K_REP, 1, 60);
    expect_ev(K_REP, 1, 80);
    expect_ev(K_REL, 1, 93);
    expect_ev(K_HFALL, 1, 93);
    wait_cyc(4);
    noisy[1] = 1'b1;
    wait_cyc(39);
    chk("c_hold_not_early", hold, 0);
    wait_cyc(40);
    chk("c_hold", hold, 2'b10);
    chk("c_repeat_at_hold", repeat_pulse, 2'b10);
    wait_cyc(41);
    chk("c_repeat_one_cycle", repeat_pulse, 0);
    wait_cyc(85);
    noisy[1] = 1'b0;
    wait_cyc(93);
    chk("c_release", release_pulse, 2'b10);
    chk("c_hold_drop", hold, 0);
    wait_cyc(120);

    // D: reset while ch0 is held and still pressed
    do_reset();
    expect_ev(K_PRESS, 0, 8);
    expect_ev(K_REP, 0, 30);
    expect_ev(K_HRISE, 0, 30);
    expect_ev(K_REP, 0, 50);
    expect_ev(K_HFALL, 0, 0);
    expect_ev(K_PRESS, 0, 8);
    expect_ev(K_REP, 0, 30);
    expect_ev(K_HRISE, 0, 30);
    expect_ev(K_REL, 0, 43);
    expect_ev(K_HFALL, 0, 43);
    noisy[0] = 1'b1;
    wait_cyc(55);
    chk("d_hold_before_reset", hold, 2'b01);
    do_reset();
    chk("d_clean_after_reset", clean, 0);
    chk("d_hold_after_reset", hold, 0);
    chk("d_strobes_after_reset", {press, release_pulse, repeat_pulse}, 0);
    chk("d_state_after_reset", state_dbg, 0);
    wait_cyc(8);
    chk("d_press_again", press, 2'b01);
    wait_cyc(35);
    noisy[0] = 1'b0;
    wait_cyc(60);

    // E: active-low instance
    do_reset();
    chk("e_clean_al_idle", clean_al, 0);
    wait_cyc(2);
    noisy_al[0] = 1'b0;
    wait_cyc(9);
    chk("e_clean_al_not_early", clean_al, 0);
    wait_cyc(10);
    chk("e_press_al", press_al, 2'b01);
    chk("e_clean_al", clean_al, 2'b01);
    wait_cyc(11);
    chk("e_press_al_one_cycle", press_al, 0);
    wait_cyc(12);
    noisy_al[0] = 1'b1;
    wait_cyc(20);
    chk("e_release_al", release_al, 2'b01);
    chk("e_clean_al_fall", clean_al, 0);
    wait_cyc(30);

    // final report
    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL sb_missing: got no event, required kind=%0d ch=%0d cyc=%0d",
               e[19:17], e[16], e[15:0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Multi-channel pushbutton conditioner. It is the parametrised successor to the single-channel debouncer.
- Per channel: 2-flop synchroniser, stability-counter debounce, press/release strobes, long-press hold flag and auto-repeat strobes.
- Sits between the raw board switches/buttons and the UI/control FSMs. Replaces per-button debouncers plus ad-hoc edge detectors.

Parameters:
NCH, 4, number of independent button channels
NDELAY, 650000, cycles a synchronised input must be stable before clean follows
NBITS, 20, debounce counter width; must satisfy 2^NBITS > NDELAY
ACTIVE_LOW, 0, 1 = buttons read 0 when pressed; input inverted before synchroniser
TICK_DIV, 65000, clk cycles per hold/repeat tick (shared prescaler)
PBITS, 17, prescaler width; 2^PBITS > TICK_DIV
HOLD_TICKS, 500, ticks after press before hold asserts (>=1)
REPEAT_TICKS, 100, ticks between repeat strobes while held; 0 = no repeats after the first
TBITS, 10, hold/repeat counter width; must hold max(HOLD_TICKS, REPEAT_TICKS)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
noisy  input  NCH  raw asynchronous button inputs
clean  output  NCH  debounced level, 1 = pressed (after polarity)
press  output  NCH  1-cycle strobe, coincident with clean rising
release  output  NCH  1-cycle strobe, coincident with clean falling
hold  output  NCH  level; 1 while pressed for at least HOLD_TICKS ticks
repeat  output  NCH  1-cycle strobe at hold entry, then every REPEAT_TICKS ticks while held

Behaviour:
- Reset (reset=1 at posedge): synchroniser flops, xnew, debounce counts, clean, press, release, hold, repeat, hold/repeat counters and prescaler all go to 0. All channels return to IDLE.
- A button held through reset produces a normal press after release of reset. There is no state carry-over.
- Polarity: in = ACTIVE_LOW ? ~noisy : noisy, applied before sync stage 1.
- Debounce, per channel, priority order:
  - (a) If sync2 != xnew: xnew <= sync2, count <= 0.
  - (b) Else if count == NDELAY: clean <= xnew, and count holds.
  - (c) Else count <= count + 1.
- Latency: input changes, then is sampled at edge 1. clean updates at edge NDELAY+4, provided the input stays stable.
- Glitch rule: any change before count reaches NDELAY restarts the count. Pulses shorter than about NDELAY+1 cycles never reach clean.
- press/release are registered. Each is high exactly the cycle clean first shows the new value, and 0 otherwise. They never both assert on one channel in the same cycle.
- Prescaler: free-running counter 0..TICK_DIV-1. tick is high for one cycle when the counter equals TICK_DIV-1, then it wraps to 0. One prescaler is shared by all channels.
- Per-channel FSM:
  - IDLE -> PRESSED on press: hold_cnt <= 0.
  - PRESSED: on tick, hold_cnt += 1. When tick arrives with hold_cnt == HOLD_TICKS-1, go to HELD; in the next cycle hold <= 1, repeat pulses, rep_cnt <= 0.
  - HELD: on tick, rep_cnt += 1. When tick arrives with rep_cnt == REPEAT_TICKS-1 (and REPEAT_TICKS != 0), repeat pulses next cycle and rep_cnt <= 0.
  - PRESSED or HELD -> IDLE on release: hold <= 0, counters cleared, no repeat.
- Release has priority over a same-cycle tick. No repeat or hold may assert in or after the release cycle.
- Hold timing jitter: hold rises between (HOLD_TICKS-1)*TICK_DIV+1 and HOLD_TICKS*TICK_DIV cycles after press, because ticks are free-running. Repeat spacing is exactly REPEAT_TICKS*TICK_DIV cycles.
- Channels are fully independent apart from the shared tick. Simultaneous activity on all channels is legal.
- Counters never wrap: the debounce count holds at NDELAY, and hold_cnt stops in HELD.

Test Plan:
Bench parameters: NCH=2, NDELAY=4, NBITS=3, TICK_DIV=10, PBITS=4, HOLD_TICKS=3, REPEAT_TICKS=2, TBITS=2, ACTIVE_LOW=0.
- Clean press: noisy[0] 0->1 held, first sampled at edge 1 -> clean[0]=1 and press[0]=1 at edge 8. press[0] is 0 at edge 9. Channel 1 outputs stay 0.
- Glitch rejection: noisy[0] toggles high for 3 cycles, low for 2, then high steady -> no press during the bounce. press occurs 8 edges after the final stable rise.
- Hold/repeat: hold noisy[1]=1 -> hold[1] rises 21..30 cycles after press[1]. repeat[1] pulses with hold, then every 20 cycles (e.g. at +20 and +40). Drop noisy[1] -> release[1] after 8 edges, hold[1]=0 that cycle, no further repeats.
- Release colliding with tick: align clean fall with a tick cycle while in HELD -> release=1, repeat=0 in that cycle and after, and the FSM is in IDLE.
- Reset mid-hold: assert reset for 1 cycle while hold[0]=1 and noisy[0] still 1 -> all outputs 0 the next cycle. press[0] reappears at 8 edges after reset deasserts, and hold follows the normal timing.
- ACTIVE_LOW=1 rebuild: noisy idle at 1 -> clean=0 after reset. Drive noisy to 0 -> press after 8 edges.
